// File: rtl/umi_arb_mux.sv
// umi_arb_mux
// ---------------------------------------------------------------------------
// N-to-1 UMI request mux with round-robin, message-atomic arbitration.
// Several UMI request streams converge onto a single UMI output. Once an input
// wins, it owns the output until it sends a beat with EOM (cmd[22]) set. The
// output goes through a one-entry register stage, so umi_out_valid and the
// payload are always driven straight from flops.
//
// Parameters
//   N   number of input ports (2..16)
//   DW  data width
//   CW  command width (must be wider than 22 so that cmd[22], EOM, exists)
//   AW  address width
//
// Ports
//   clk              in   clock, all state updates on the rising edge
//   reset            in   synchronous active-high reset
//   umi_in_valid     in   [N]     per-input valid
//   umi_in_cmd       in   [N*CW]  per-input command, input i at [i*CW +: CW]
//   umi_in_dstaddr   in   [N*AW]  per-input destination address
//   umi_in_srcaddr   in   [N*AW]  per-input source address
//   umi_in_data      in   [N*DW]  per-input data
//   umi_in_ready     out  [N]     per-input ready
//   umi_out_valid    out          output valid (registered)
//   umi_out_cmd      out  [CW]    output command (registered)
//   umi_out_dstaddr  out  [AW]    output destination address (registered)
//   umi_out_srcaddr  out  [AW]    output source address (registered)
//   umi_out_data     out  [DW]    output data (registered)
//   umi_out_ready    in           output ready
// ---------------------------------------------------------------------------
module umi_arb_mux #(
  parameter int N  = 4,
  parameter int DW = 256,
  parameter int CW = 32,
  parameter int AW = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    umi_in_valid,
  input  logic [N*CW-1:0] umi_in_cmd,
  input  logic [N*AW-1:0] umi_in_dstaddr,
  input  logic [N*AW-1:0] umi_in_srcaddr,
  input  logic [N*DW-1:0] umi_in_data,
  output logic [N-1:0]    umi_in_ready,
  output logic            umi_out_valid,
  output logic [CW-1:0]   umi_out_cmd,
  output logic [AW-1:0]   umi_out_dstaddr,
  output logic [AW-1:0]   umi_out_srcaddr,
  output logic [DW-1:0]   umi_out_data,
  input  logic            umi_out_ready
);

  localparam int IW      = (N > 1) ? $clog2(N) : 1;
  localparam int EOM_BIT = 22;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [IW-1:0] rr_q;
  logic [IW-1:0] rr_d;
  logic [IW-1:0] lock_idx_q;
  logic [IW-1:0] lock_idx_d;

  logic [IW-1:0] grant;
  logic          grant_vld;
  logic [IW:0]   cand;
  logic          accept;
  logic          xfer;
  logic          sel_eom;
  logic [CW-1:0] sel_cmd;
  logic [AW-1:0] sel_dstaddr;
  logic [AW-1:0] sel_srcaddr;
  logic [DW-1:0] sel_data;

  // The output stage can take a new beat when it is empty or being drained
  // this very cycle.
  assign accept = !umi_out_valid | umi_out_ready;

  // Arbitration. While locked the owner keeps the grant even when its valid
  // drops (a bubble mid-message), so nobody else can slip in. Otherwise search
  // upward from the round-robin pointer. The candidate is one bit wider than
  // the index so rr + k cannot overflow before the explicit mod-N wrap, which
  // keeps non-power-of-2 N correct.
  always_comb begin
    grant     = lock_idx_q;
    grant_vld = 1'b0;
    cand      = '0;
    if (state_q == LOCKED) begin
      grant     = lock_idx_q;
      grant_vld = 1'b1;
    end else begin
      for (int k = 0; k < N; k++) begin
        cand = {1'b0, rr_q} + (IW+1)'(k);
        if (cand >= (IW+1)'(N)) begin
          cand = cand - (IW+1)'(N);
        end
        if (!grant_vld && umi_in_valid[cand[IW-1:0]]) begin
          grant     = cand[IW-1:0];
          grant_vld = 1'b1;
        end
      end
    end
  end

  // Ready goes only to the granted input and only when the stage can accept.
  always_comb begin
    umi_in_ready = '0;
    for (int i = 0; i < N; i++) begin
      umi_in_ready[i] = accept & grant_vld & (grant == IW'(i));
    end
  end

  // Payload select for the granted input.
  always_comb begin
    sel_cmd     = '0;
    sel_dstaddr = '0;
    sel_srcaddr = '0;
    sel_data    = '0;
    for (int i = 0; i < N; i++) begin
      if (grant == IW'(i)) begin
        sel_cmd     = umi_in_cmd[i*CW +: CW];
        sel_dstaddr = umi_in_dstaddr[i*AW +: AW];
        sel_srcaddr = umi_in_srcaddr[i*AW +: AW];
        sel_data    = umi_in_data[i*DW +: DW];
      end
    end
  end

  assign xfer    = grant_vld & umi_in_valid[grant] & accept;
  assign sel_eom = sel_cmd[EOM_BIT];

  // Lock FSM and round-robin pointer, next-state logic. The pointer moves
  // past an input only when that input finishes a message, so a long
  // multi-beat message does not cost it its turn.
  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    rr_d       = rr_q;
    case (state_q)
      IDLE: begin
        if (xfer && !sel_eom) begin
          state_d    = LOCKED;
          lock_idx_d = grant;
        end
      end
      LOCKED: begin
        if (xfer && sel_eom) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (xfer && sel_eom) begin
      rr_d = (grant == IW'(N - 1)) ? '0 : grant + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      lock_idx_q <= '0;
      rr_q       <= '0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
      rr_q       <= rr_d;
    end
  end

  // Output stage. A transfer always refills the stage, even while the
  // current beat is leaving, which gives one beat per cycle. The payload only
  // changes on a transfer, so it holds steady under backpressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      umi_out_valid   <= 1'b0;
      umi_out_cmd     <= '0;
      umi_out_dstaddr <= '0;
      umi_out_srcaddr <= '0;
      umi_out_data    <= '0;
    end else if (xfer) begin
      umi_out_valid   <= 1'b1;
      umi_out_cmd     <= sel_cmd;
      umi_out_dstaddr <= sel_dstaddr;
      umi_out_srcaddr <= sel_srcaddr;
      umi_out_data    <= sel_data;
    end else if (umi_out_valid && umi_out_ready) begin
      umi_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_umi_arb_mux.sv
// tb_umi_arb_mux
// ---------------------------------------------------------------------------
// Self-checking bench for umi_arb_mux (N=4). Per-input beat queues feed the
// DUT with ready/valid semantics; a behavioural model (owner / round-robin
// pointer / one-entry output buffer) predicts ready and the output stage every
// cycle. Directed scenarios add literal expectations on the delivered order.
// ---------------------------------------------------------------------------
module tb_umi_arb_mux;

  localparam int N   = 4;
  localparam int DW  = 64;
  localparam int CW  = 32;
  localparam int AW  = 64;
  localparam int EOM = 22;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    umi_in_valid;
  logic [N*CW-1:0] umi_in_cmd;
  logic [N*AW-1:0] umi_in_dstaddr;
  logic [N*AW-1:0] umi_in_srcaddr;
  logic [N*DW-1:0] umi_in_data;
  logic [N-1:0]    umi_in_ready;
  logic            umi_out_valid;
  logic [CW-1:0]   umi_out_cmd;
  logic [AW-1:0]   umi_out_dstaddr;
  logic [AW-1:0]   umi_out_srcaddr;
  logic [DW-1:0]   umi_out_data;
  logic            umi_out_ready;

  always #5 clk = ~clk;

  umi_arb_mux #(.N(N), .DW(DW), .CW(CW), .AW(AW)) dut (
    .clk             (clk),
    .reset           (reset),
    .umi_in_valid    (umi_in_valid),
    .umi_in_cmd      (umi_in_cmd),
    .umi_in_dstaddr  (umi_in_dstaddr),
    .umi_in_srcaddr  (umi_in_srcaddr),
    .umi_in_data     (umi_in_data),
    .umi_in_ready    (umi_in_ready),
    .umi_out_valid   (umi_out_valid),
    .umi_out_cmd     (umi_out_cmd),
    .umi_out_dstaddr (umi_out_dstaddr),
    .umi_out_srcaddr (umi_out_srcaddr),
    .umi_out_data    (umi_out_data),
    .umi_out_ready   (umi_out_ready)
  );

  typedef struct {
    logic [CW-1:0] cmd;
    logic [AW-1:0] dst;
    logic [AW-1:0] src;
    logic [DW-1:0] data;
    int            gap;
  } beat_t;

  beat_t pend [N][$];
  beat_t cur [N];
  bit    cur_valid [N];
  bit    hs [N];
  int    wait_cnt [N];
  int    tag_ctr = 0;
  int    ready_mode = 0;
  bit    rst_next = 1'b1;
  int    log_src[$];
  int    log_tag[$];

  int    vectors = 0;
  int    miscompares = 0;

  // model state, owned by the compare process
  int            m_owner = -1;
  int            m_rr = 0;
  bit            m_v = 1'b0;
  logic [CW-1:0] m_cmd = '0;
  logic [AW-1:0] m_dst = '0;
  logic [AW-1:0] m_src = '0;
  logic [DW-1:0] m_data = '0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pushBeat(input int i, input bit eom, input int gap,
                          input logic [AW-1:0] dst, input logic [DW-1:0] data);
    beat_t b;
    b.cmd      = $urandom;
    b.cmd[EOM] = eom;
    b.dst      = dst;
    b.src      = (64'(tag_ctr) << 4) | 64'(i);
    b.data     = data;
    b.gap      = gap;
    tag_ctr++;
    pend[i].push_back(b);
  endtask

  task automatic pushRand(input int i, input bit eom, input int gap);
    pushBeat(i, eom, gap, {$urandom, $urandom}, {$urandom, $urandom});
  endtask

  // One clock: update sources after the edge, then sample handshakes and
  // delivered beats at the falling edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    reset = rst_next;
    for (int i = 0; i < N; i++) begin
      if (cur_valid[i] && hs[i]) cur_valid[i] = 1'b0;
      if (!cur_valid[i] && pend[i].size() > 0) begin
        if (wait_cnt[i] < pend[i][0].gap) begin
          wait_cnt[i]++;
        end else begin
          cur[i]       = pend[i].pop_front();
          cur_valid[i] = 1'b1;
          wait_cnt[i]  = 0;
        end
      end
      umi_in_valid[i]             = cur_valid[i];
      umi_in_cmd[i*CW +: CW]      = cur[i].cmd;
      umi_in_dstaddr[i*AW +: AW]  = cur[i].dst;
      umi_in_srcaddr[i*AW +: AW]  = cur[i].src;
      umi_in_data[i*DW +: DW]     = cur[i].data;
    end
    umi_out_ready = (ready_mode == 0) ? 1'b1 :
                    (ready_mode == 2) ? 1'b0 : ($urandom_range(0, 99) < 70);
    @(negedge clk);
    for (int i = 0; i < N; i++) hs[i] = cur_valid[i] && umi_in_ready[i];
    if (umi_out_valid && umi_out_ready && !reset) begin
      log_src.push_back(int'(umi_out_srcaddr[3:0]));
      log_tag.push_back(int'(umi_out_srcaddr[35:4]));
    end
  endtask

  task automatic waitIdle(input string name, input int budget);
    int n = 0;
    bit busy;
    do begin
      applyStimulus();
      n++;
      busy = umi_out_valid;
      for (int i = 0; i < N; i++) busy |= cur_valid[i] || (pend[i].size() > 0);
    end while (busy && n < budget);
    checkOutput({name, "_drained"}, 64'(busy), 64'd0);
  endtask

  task automatic doReset();
    rst_next = 1'b1;
    applyStimulus();
    rst_next = 1'b0;
  endtask

  // Compare process: the model knows only who owns the output, where the
  // round-robin search starts and what sits in the one-entry output buffer.
  initial begin : compare
    int g;
    bit acc;
    logic [N-1:0] exp_rdy;
    @(posedge clk);
    forever begin
      @(negedge clk);
      g = -1;
      if (m_owner >= 0) begin
        g = m_owner;
      end else begin
        for (int k = 0; k < N; k++) begin
          if (g < 0 && umi_in_valid[(m_rr + k) % N]) g = (m_rr + k) % N;
        end
      end
      acc = !m_v || umi_out_ready;
      exp_rdy = '0;
      if (acc && g >= 0) exp_rdy[g] = 1'b1;
      checkOutput("in_ready", 64'(umi_in_ready), 64'(exp_rdy));
      checkOutput("out_valid", 64'(umi_out_valid), 64'(m_v));
      if (m_v) begin
        checkOutput("out_cmd", 64'(umi_out_cmd), 64'(m_cmd));
        checkOutput("out_dstaddr", umi_out_dstaddr, m_dst);
        checkOutput("out_srcaddr", umi_out_srcaddr, m_src);
        checkOutput("out_data", umi_out_data, m_data);
      end
      if (reset) begin
        m_owner = -1;
        m_rr    = 0;
        m_v     = 1'b0;
      end else if (g >= 0 && acc && umi_in_valid[g]) begin
        m_v    = 1'b1;
        m_cmd  = umi_in_cmd[g*CW +: CW];
        m_dst  = umi_in_dstaddr[g*AW +: AW];
        m_src  = umi_in_srcaddr[g*AW +: AW];
        m_data = umi_in_data[g*DW +: DW];
        if (m_cmd[EOM]) begin
          m_owner = -1;
          m_rr    = (g + 1) % N;
        end else begin
          m_owner = g;
        end
      end else if (m_v && umi_out_ready) begin
        m_v = 1'b0;
      end
    end
  end

  initial begin : driver
    int n;
    int bad;
    int cnt [N];
    int first_tag;
    int total;
    int exp3 [4] = '{1, 1, 1, 0};
    int exp4 [3] = '{3, 3, 0};

    reset          = 1'b1;
    umi_in_valid   = '0;
    umi_in_cmd     = '0;
    umi_in_dstaddr = '0;
    umi_in_srcaddr = '0;
    umi_in_data    = '0;
    umi_out_ready  = 1'b1;
    for (int i = 0; i < N; i++) begin
      cur[i]       = '{cmd: '0, dst: '0, src: '0, data: '0, gap: 0};
      cur_valid[i] = 1'b0;
      hs[i]        = 1'b0;
      wait_cnt[i]  = 0;
    end

    // reset state
    applyStimulus();
    applyStimulus();
    checkOutput("rst_out_valid", 64'(umi_out_valid), 64'd0);
    checkOutput("rst_out_cmd", 64'(umi_out_cmd), 64'd0);
    checkOutput("rst_out_data", umi_out_data, 64'd0);
    checkOutput("rst_in_ready", 64'(umi_in_ready), 64'd0);
    rst_next = 1'b0;

    // single beat from input 2
    $display("[TB] single input");
    pushBeat(2, 1'b1, 0, 64'h100, 64'hA5);
    n = 0;
    do begin applyStimulus(); n++; end while (!hs[2] && n < 20);
    checkOutput("single_handshake", 64'(hs[2]), 64'd1);
    applyStimulus();
    checkOutput("single_valid", 64'(umi_out_valid), 64'd1);
    checkOutput("single_dst", umi_out_dstaddr, 64'h100);
    checkOutput("single_data", umi_out_data, 64'hA5);
    checkOutput("single_model_rr", 64'(m_rr), 64'd3);
    waitIdle("single", 20);

    // fairness
    $display("[TB] fairness");
    doReset();
    log_src.delete();
    log_tag.delete();
    for (int k = 0; k < 25; k++)
      for (int i = 0; i < N; i++) pushRand(i, 1'b1, 0);
    waitIdle("fair", 300);
    checkOutput("fair_count", 64'(log_src.size()), 64'd100);
    bad = 0;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    foreach (log_src[k]) begin
      if (log_src[k] != k % N) bad++;
      if (log_src[k] < N) cnt[log_src[k]]++;
    end
    checkOutput("fair_order", 64'(bad), 64'd0);
    for (int i = 0; i < N; i++) checkOutput($sformatf("fair_share%0d", i), 64'(cnt[i]), 64'd25);

    // message atomicity: one beat from 0 moves rr to 1 first
    $display("[TB] atomicity");
    pushRand(0, 1'b1, 0);
    waitIdle("atom_pre", 20);
    log_src.delete();
    pushRand(1, 1'b0, 0);
    pushRand(1, 1'b0, 0);
    pushRand(1, 1'b1, 0);
    pushRand(0, 1'b1, 0);
    waitIdle("atom", 40);
    checkOutput("atom_count", 64'(log_src.size()), 64'd4);
    for (int k = 0; k < 4; k++)
      checkOutput($sformatf("atom_seq%0d", k), 64'(log_src[k]), 64'(exp3[k]));

    // mid-message bubble: one beat from 2 moves rr to 3 first
    $display("[TB] bubble");
    pushRand(2, 1'b1, 0);
    waitIdle("bubble_pre", 20);
    log_src.delete();
    pushRand(3, 1'b0, 0);
    pushRand(3, 1'b1, 5);
    pushRand(0, 1'b1, 0);
    waitIdle("bubble", 50);
    checkOutput("bubble_count", 64'(log_src.size()), 64'd3);
    for (int k = 0; k < 3; k++)
      checkOutput($sformatf("bubble_seq%0d", k), 64'(log_src[k]), 64'(exp4[k]));

    // backpressure
    $display("[TB] backpressure");
    log_tag.delete();
    ready_mode = 2;
    first_tag = tag_ctr;
    for (int k = 0; k < 6; k++) pushRand(0, 1'b1, 0);
    n = 0;
    repeat (10) begin
      applyStimulus();
      if (hs[0]) n++;
    end
    checkOutput("bp_accepted", 64'(n), 64'd1);
    ready_mode = 0;
    waitIdle("bp", 40);
    checkOutput("bp_count", 64'(log_tag.size()), 64'd6);
    bad = 0;
    foreach (log_tag[k]) if (log_tag[k] != first_tag + k) bad++;
    checkOutput("bp_order", 64'(bad), 64'd0);

    // reset while locked on input 2 with the output stage full
    $display("[TB] reset mid-message");
    pushRand(2, 1'b0, 0);
    pushRand(2, 1'b0, 0);
    pushRand(2, 1'b1, 0);
    n = 0;
    do begin applyStimulus(); n++; end while (!hs[2] && n < 20);
    checkOutput("rstmid_handshake", 64'(hs[2]), 64'd1);
    pushRand(0, 1'b1, 0);
    pushRand(1, 1'b1, 0);
    pushRand(3, 1'b1, 0);
    rst_next = 1'b1;
    applyStimulus();
    checkOutput("rstmid_full", 64'(umi_out_valid), 64'd1);
    rst_next = 1'b0;
    log_src.delete();
    applyStimulus();
    checkOutput("rstmid_out_valid", 64'(umi_out_valid), 64'd0);
    checkOutput("rstmid_in_ready", 64'(umi_in_ready), 64'b0001);
    waitIdle("rstmid", 40);
    checkOutput("rstmid_first", 64'(log_src[0]), 64'd0);

    // randomized traffic with random backpressure and mid-message gaps
    $display("[TB] random traffic");
    doReset();
    log_src.delete();
    ready_mode = 1;
    total = 0;
    for (int i = 0; i < N; i++) begin
      for (int m = 0; m < 12; m++) begin
        int len = $urandom_range(1, 4);
        for (int b = 0; b < len; b++) begin
          pushRand(i, b == len - 1, $urandom_range(0, 3));
          total++;
        end
      end
    end
    waitIdle("rand", 4000);
    checkOutput("rand_count", 64'(log_src.size()), 64'(total));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
